// File: rtl/sram_fifo_if.sv
// sram_fifo_if: handshake and status bundle between a FIFO user and sram_fifo.
//   master  - user side: drives flush, enqueue_en/value, dequeue_en;
//             observes full, almost_full, empty, almost_empty, dequeue_value.
//   slave   - FIFO side: the mirror image of master.
interface sram_fifo_if #(
    parameter int WIDTH = 64
);
    logic             flush;
    logic             full;
    logic             almost_full;
    logic             enqueue_en;
    logic [WIDTH-1:0] enqueue_value;
    logic             empty;
    logic             almost_empty;
    logic             dequeue_en;
    logic [WIDTH-1:0] dequeue_value;

    modport master (
        output flush, enqueue_en, enqueue_value, dequeue_en,
        input  full, almost_full, empty, almost_empty, dequeue_value
    );

    modport slave (
        input  flush, enqueue_en, enqueue_value, dequeue_en,
        output full, almost_full, empty, almost_empty, dequeue_value
    );
endinterface

// File: rtl/sram_fifo.sv
// sram_1r1w: one write port, one registered read port (one-cycle read latency).
//   clk, write_en/write_addr/write_data, read_en/read_addr -> read_data.
//   read_data holds its value while read_en is low. With READ_DURING_WRITE
//   "DONT_CARE" a same-address read returns unspecified data; "NEW_DATA"
//   forwards the write data.
//
// sram_fifo: first-word-fall-through FIFO built on sram_1r1w.
//   clk, reset (sync, active-high), fifo (sram_fifo_if.slave): flush,
//   enqueue_en/value, dequeue_en in; full, almost_full, empty, almost_empty,
//   dequeue_value out. dequeue_value is valid whenever empty is low.
module sram_1r1w #(
    parameter int WIDTH             = 64,
    parameter int DEPTH             = 8,
    parameter     READ_DURING_WRITE = "DONT_CARE",
    localparam int AW               = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             write_en,
    input  logic [AW-1:0]    write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_en,
    input  logic [AW-1:0]    read_addr,
    output logic [WIDTH-1:0] read_data
);
    localparam bit FWD_NEW = (READ_DURING_WRITE == "NEW_DATA");

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en)
            mem[write_addr] <= write_data;
    end

    always_ff @(posedge clk) begin
        if (read_en) begin
            if (FWD_NEW && write_en && (write_addr == read_addr))
                read_data <= write_data;
            else
                read_data <= mem[read_addr];
        end
    end
endmodule

module sram_fifo #(
    parameter int WIDTH                  = 64,
    parameter int SIZE                   = 8,
    parameter int ALMOST_FULL_THRESHOLD  = SIZE,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    sram_fifo_if.slave  fifo
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
    localparam logic [CW-1:0] AF_TH  = CW'(ALMOST_FULL_THRESHOLD);
    localparam logic [CW-1:0] AE_TH  = CW'(ALMOST_EMPTY_THRESHOLD);

    logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [CW-1:0]    count, count_next;
    logic             clear, do_enq, do_deq;
    logic             head_valid;
    logic             write_en, read_en, bypass_hit;
    logic [AW-1:0]    read_addr;
    logic [WIDTH-1:0] read_data;
    logic             bypass_sel;
    logic [WIDTH-1:0] bypass_data;
    logic             empty_q, full_q, almost_empty_q, almost_full_q;

    // reset outranks flush, and both outrank enqueue/dequeue
    assign clear  = reset | fifo.flush;
    assign do_enq = fifo.enqueue_en & ~clear;
    assign do_deq = fifo.dequeue_en & ~clear;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_enq) wr_ptr_next = wr_ptr + AW'(1);
            if (do_deq) rd_ptr_next = rd_ptr + AW'(1);
            case ({do_enq, do_deq})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // Prefetch the entry that will be the head after this edge. A read is
    // only needed when the head moves or when it has not been loaded yet.
    assign write_en   = do_enq;
    assign read_addr  = rd_ptr + AW'(fifo.dequeue_en);
    assign read_en    = ~clear & (do_deq | (~head_valid & ((count != '0) | do_enq)));
    // The SRAM gives no guarantee on a same-address read during write, so
    // capture the incoming word locally and present it instead.
    assign bypass_hit = read_en & write_en & (read_addr == wr_ptr);

    sram_1r1w #(
        .WIDTH             (WIDTH),
        .DEPTH             (SIZE),
        .READ_DURING_WRITE ("DONT_CARE")
    ) u_sram (
        .clk        (clk),
        .write_en   (write_en),
        .write_addr (wr_ptr),
        .write_data (fifo.enqueue_value),
        .read_en    (read_en),
        .read_addr  (read_addr),
        .read_data  (read_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            head_valid     <= 1'b0;
            bypass_sel     <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            if (clear)
                bypass_sel <= 1'b0;
            else if (read_en)
                bypass_sel <= bypass_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (bypass_hit)
            bypass_data <= fifo.enqueue_value;
    end

    // Flags come from the next-state count so they move on the accepting edge.
    // count_next is already zero under reset, giving the reset flag values.
    always_ff @(posedge clk) begin
        empty_q        <= (count_next == '0);
        full_q         <= (count_next == SIZE_C);
        almost_empty_q <= (count_next <= AE_TH);
        almost_full_q  <= (count_next >= AF_TH);
    end

    assign fifo.empty         = empty_q;
    assign fifo.full          = full_q;
    assign fifo.almost_empty  = almost_empty_q;
    assign fifo.almost_full   = almost_full_q;
    assign fifo.dequeue_value = bypass_sel ? bypass_data : read_data;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && !fifo.flush) begin
            assert (!(fifo.enqueue_en && full_q && !fifo.dequeue_en))
                else $error("sram_fifo: enqueue while full");
            assert (!(fifo.dequeue_en && empty_q))
                else $error("sram_fifo: dequeue while empty");
        end
    end
`endif
endmodule

// File: tb/tb_sram_fifo.sv
module tb_sram_fifo;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    sram_fifo_if #(.WIDTH(64)) bus ();

    sram_fifo #(.WIDTH(64), .SIZE(8)) dut (
        .clk   (clk),
        .reset (reset),
        .fifo  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic enq, input logic [63:0] val,
                         input logic deq, input logic fl);
        bus.enqueue_en    = enq;
        bus.enqueue_value = val;
        bus.dequeue_en    = deq;
        bus.flush         = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // enqueue and flush during reset must be ignored
        drive(1'b1, 64'hDEAD, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_almost_empty: got %b want 1", bus.almost_empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_cmp++; if (bus.almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_almost_full: got %b want 0", bus.almost_full); end
    endtask

    task automatic test_first_enqueue();
        do_reset();
        drive(1'b1, 64'hA, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        n_cmp++; if (bus.empty !== 1'b0) begin n_bad++; $display("FAIL first_enq_empty: got %b want 0", bus.empty); end
        n_cmp++; if (bus.dequeue_value !== 64'hA) begin n_bad++; $display("FAIL first_enq_value: got %h want %h", bus.dequeue_value, 64'hA); end
        n_cmp++; if (bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL first_enq_almost_empty: got %b want 1", bus.almost_empty); end
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL first_deq_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 1'b0, 1'b0);
            tick();
            n_cmp++; if (bus.full !== (i == 8)) begin n_bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, (i == 8)); end
            n_cmp++; if (bus.almost_full !== (i == 8)) begin n_bad++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, bus.almost_full, (i == 8)); end
            n_cmp++; if (bus.almost_empty !== (i == 1)) begin n_bad++; $display("FAIL fill_almost_empty[%0d]: got %b want %b", i, bus.almost_empty, (i == 1)); end
            n_cmp++; if (bus.dequeue_value !== 64'h1) begin n_bad++; $display("FAIL fill_head[%0d]: got %h want 1", i, bus.dequeue_value); end
        end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (bus.dequeue_value !== 64'(i)) begin n_bad++; $display("FAIL drain_value[%0d]: got %h want %h", i, bus.dequeue_value, 64'(i)); end
            n_cmp++; if (bus.empty !== 1'b0) begin n_bad++; $display("FAIL drain_empty[%0d]: got %b want 0", i, bus.empty); end
            drive(1'b0, 64'h0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL drain_final_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL drain_final_full: got %b want 0", bus.full); end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1'b1, 64'h5, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus.dequeue_value !== 64'h5) begin n_bad++; $display("FAIL bypass_head0: got %h want 5", bus.dequeue_value); end
        drive(1'b1, 64'h6, 1'b1, 1'b0);
        tick();
        n_cmp++; if (bus.dequeue_value !== 64'h6) begin n_bad++; $display("FAIL bypass_head1: got %h want 6", bus.dequeue_value); end
        n_cmp++; if (bus.empty !== 1'b0) begin n_bad++; $display("FAIL bypass_empty1: got %b want 0", bus.empty); end
        n_cmp++; if (bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL bypass_almost_empty1: got %b want 1", bus.almost_empty); end
        drive(1'b1, 64'h7, 1'b1, 1'b0);
        tick();
        n_cmp++; if (bus.dequeue_value !== 64'h7) begin n_bad++; $display("FAIL bypass_head2: got %h want 7", bus.dequeue_value); end
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL bypass_count1_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_full_stream();
        logic [63:0] q[$];
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 1'b0, 1'b0);
            tick();
            q.push_back(64'(i));
        end
        for (int k = 0; k < 20; k++) begin
            n_cmp++; if (bus.dequeue_value !== q[0]) begin n_bad++; $display("FAIL stream_head[%0d]: got %h want %h", k, bus.dequeue_value, q[0]); end
            drive(1'b1, 64'h900 + 64'(k), 1'b1, 1'b0);
            tick();
            void'(q.pop_front());
            q.push_back(64'h900 + 64'(k));
            n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL stream_full[%0d]: got %b want 1", k, bus.full); end
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.dequeue_value !== q[0]) begin n_bad++; $display("FAIL stream_drain[%0d]: got %h want %h", i, bus.dequeue_value, q[0]); end
            drive(1'b0, 64'h0, 1'b1, 1'b0);
            tick();
            void'(q.pop_front());
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL stream_final_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 64'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 64'h77, 1'b1, 1'b1);
        tick();
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL flush_full: got %b want 0", bus.full); end
        n_cmp++; if (bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL flush_almost_empty: got %b want 1", bus.almost_empty); end
        drive(1'b1, 64'h3, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus.dequeue_value !== 64'h3) begin n_bad++; $display("FAIL flush_refill_value: got %h want 3", bus.dequeue_value); end
        n_cmp++; if (bus.empty !== 1'b0) begin n_bad++; $display("FAIL flush_refill_empty: got %b want 0", bus.empty); end
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL flush_refill_drain: got %b want 1", bus.empty); end
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic        enq, deq, fl;
        logic [63:0] val;
        int          sz;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            sz  = q.size();
            fl  = ($urandom_range(0, 199) == 0);
            deq = (sz > 0) && ($urandom_range(0, 1) == 1);
            enq = ($urandom_range(0, 1) == 1) && ((sz < 8) || deq);
            val = {$urandom, $urandom};
            if (sz > 0) begin
                n_cmp++; if (bus.dequeue_value !== q[0]) begin n_bad++; $display("FAIL rand_head[%0d]: got %h want %h", c, bus.dequeue_value, q[0]); end
            end
            drive(enq, val, deq, fl);
            tick();
            if (fl) begin
                q.delete();
            end else begin
                if (deq) void'(q.pop_front());
                if (enq) q.push_back(val);
            end
            sz = q.size();
            n_cmp++; if (bus.empty !== (sz == 0)) begin n_bad++; $display("FAIL rand_empty[%0d]: got %b want %b", c, bus.empty, (sz == 0)); end
            n_cmp++; if (bus.full !== (sz == 8)) begin n_bad++; $display("FAIL rand_full[%0d]: got %b want %b", c, bus.full, (sz == 8)); end
            n_cmp++; if (bus.almost_empty !== (sz <= 1)) begin n_bad++; $display("FAIL rand_almost_empty[%0d]: got %b want %b", c, bus.almost_empty, (sz <= 1)); end
            n_cmp++; if (bus.almost_full !== (sz >= 8)) begin n_bad++; $display("FAIL rand_almost_full[%0d]: got %b want %b", c, bus.almost_full, (sz >= 8)); end
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        test_reset();
        test_first_enqueue();
        test_fill_drain();
        test_bypass();
        test_full_stream();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
